dispatch_rr_multi_fu: RTL and testbench

// - Parametrised dispatch stage between rename and NUM_FU reservation stations.
// - Buffers renamed ops in per-FU FIFOs; round-robin arbiter issues 1 op/cycle to ROB + selected RS.
// - Sets dest busy in PRF at accept; source readiness = PRF query OR NUM_CDB-wide CDB snoop at grant.
// - Non-selected FUs never stall rename (per-FU back-pressure).

---
 rtl/dispatch_rr_multi_fu.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dispatch_rr_multi_fu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_rr_multi_fu.sv
// Dispatch stage: per-FU op FIFOs feeding the ROB and one reservation station per cycle via round-robin.
// Optional same-cycle bypass of an empty FIFO is enabled by defining DISPATCH_BYPASS_EN.
`timescale 1ns/1ps
module dispatch_rr_multi_fu #(
    parameter int NUM_FU     = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int NUM_CDB    = 3,
    parameter int PREG_W     = 7,
    parameter int ROB_TAG_W  = 5,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_FU-1:0]         in_fu_sel,
    input  logic [PREG_W-1:0]         in_ps1,
    input  logic [PREG_W-1:0]         in_ps2,
    input  logic [PREG_W-1:0]         in_pd_new,
    input  logic [PREG_W-1:0]         in_pd_old,
    input  logic [31:0]               in_pc,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    output logic                      nr_valid,
    output logic [PREG_W-1:0]         nr_reg,
    output logic [PREG_W-1:0]         query_ps1,
    output logic [PREG_W-1:0]         query_ps2,
    input  logic                      pr1_is_ready,
    input  logic                      pr2_is_ready,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0] cdb_tag,
    input  logic                      rob_full,
    input  logic [ROB_TAG_W-1:0]      rob_tag_in,
    output logic                      rob_we,
    output logic [PREG_W-1:0]         rob_pd_new,
    output logic [PREG_W-1:0]         rob_pd_old,
    output logic [31:0]               rob_pc,
    input  logic [NUM_FU-1:0]         rs_has_space,
    output logic [NUM_FU-1:0]         rs_we,
    output logic [31:0]               rs_pc,
    output logic [PREG_W-1:0]         rs_prd,
    output logic [PREG_W-1:0]         rs_pr1,
    output logic [PREG_W-1:0]         rs_pr2,
    output logic                      rs_pr1_rdy,
    output logic                      rs_pr2_rdy,
    output logic [ROB_TAG_W-1:0]      rs_rob_idx,
    output logic [PAYLOAD_W-1:0]      rs_payload
);

    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [PREG_W-1:0]    ps1;
        logic [PREG_W-1:0]    ps2;
        logic [PREG_W-1:0]    pd_new;
        logic [PREG_W-1:0]    pd_old;
        logic [31:0]          pc;
        logic [PAYLOAD_W-1:0] payload;
    } op_t;

    // A source is ready if it is x0, the PRF says so, or a valid CDB port is broadcasting it now.
    function automatic logic src_ready(
        input logic [PREG_W-1:0]         tag,
        input logic                      prf_rdy,
        input logic [NUM_CDB-1:0]        cv,
        input logic [NUM_CDB*PREG_W-1:0] ct
    );
        logic hit;
        hit = (tag == {PREG_W{1'b0}}) || prf_rdy;
        for (int k = 0; k < NUM_CDB; k++) begin
            hit = hit || (cv[k] && (ct[k*PREG_W +: PREG_W] == tag));
        end
        return hit;
    endfunction

    op_t               fifo_mem_r [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r   [NUM_FU];
    logic [PTR_W-1:0]  rd_ptr_r   [NUM_FU];
    logic [CNT_W-1:0]  count_r    [NUM_FU];
    logic [FU_W-1:0]   rr_ptr_r;

    op_t               in_op_s;
    op_t               grant_op_s;
    logic              sel_any_s;
    logic [FU_W-1:0]   sel_idx_s;
    logic [NUM_FU-1:0] full_s;
    logic [NUM_FU-1:0] nonempty_s;
    logic [NUM_FU-1:0] elig_s;
    logic [NUM_FU-1:0] push_s;
    logic [NUM_FU-1:0] pop_s;
    logic              accept_s;
    logic [FU_W:0]     cand_s;
    logic              q_grant_s;
    logic [FU_W-1:0]   q_idx_s;
    logic              byp_grant_s;
    logic              grant_s;
    logic [FU_W-1:0]   grant_idx_s;
    logic [FU_W-1:0]   next_rr_s;

    assign in_op_s = '{ps1: in_ps1, ps2: in_ps2, pd_new: in_pd_new, pd_old: in_pd_old,
                       pc: in_pc, payload: in_payload};

    // Target FU: lowest set bit of in_fu_sel (descending scan so the lowest index wins)
    always_comb begin
        sel_any_s = 1'b0;
        sel_idx_s = {FU_W{1'b0}};
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (in_fu_sel[i]) begin
                sel_any_s = 1'b1;
                sel_idx_s = FU_W'(i);
            end else begin
                sel_any_s = sel_any_s;
            end
        end
    end

    // Per-FU occupancy flags and issue eligibility
    always_comb begin
        full_s     = {NUM_FU{1'b0}};
        nonempty_s = {NUM_FU{1'b0}};
        elig_s     = {NUM_FU{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            full_s[i]     = (count_r[i] == CNT_W'(FIFO_DEPTH));
            nonempty_s[i] = (count_r[i] != {CNT_W{1'b0}});
            elig_s[i]     = nonempty_s[i] && rs_has_space[i] && !rob_full && !flush;
        end
    end

    // Full FIFO blocks acceptance even if it pops this cycle; zero select is accepted and dropped.
    assign in_ready = !flush && !(sel_any_s && full_s[sel_idx_s]);
    assign accept_s = in_valid && in_ready;
    assign nr_valid = accept_s && sel_any_s && (in_pd_new != {PREG_W{1'b0}});
    assign nr_reg   = in_pd_new;

    // Round-robin search starting at rr_ptr_r, wrapping modulo NUM_FU
    always_comb begin
        q_grant_s = 1'b0;
        q_idx_s   = {FU_W{1'b0}};
        cand_s    = {(FU_W+1){1'b0}};
        for (int k = 0; k < NUM_FU; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (FU_W+1)'(k);
            if (cand_s >= (FU_W+1)'(NUM_FU)) begin
                cand_s = cand_s - (FU_W+1)'(NUM_FU);
            end else begin
                cand_s = cand_s;
            end
            if (!q_grant_s && elig_s[cand_s[FU_W-1:0]]) begin
                q_grant_s = 1'b1;
                q_idx_s   = cand_s[FU_W-1:0];
            end else begin
                q_grant_s = q_grant_s;
            end
        end
    end

`ifdef DISPATCH_BYPASS_EN
    assign byp_grant_s = !q_grant_s && accept_s && sel_any_s && !nonempty_s[sel_idx_s]
                         && rs_has_space[sel_idx_s] && !rob_full;
`else
    assign byp_grant_s = 1'b0;
`endif

    assign grant_s     = q_grant_s || byp_grant_s;
    assign grant_idx_s = byp_grant_s ? sel_idx_s : q_idx_s;
    assign grant_op_s  = byp_grant_s ? in_op_s : fifo_mem_r[q_idx_s][rd_ptr_r[q_idx_s]];
    assign next_rr_s   = (grant_idx_s == FU_W'(NUM_FU - 1)) ? {FU_W{1'b0}}
                                                            : grant_idx_s + FU_W'(1);

    // FIFO push/pop strobes; a bypassed op never enters its FIFO
    always_comb begin
        push_s = {NUM_FU{1'b0}};
        pop_s  = {NUM_FU{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            push_s[i] = accept_s && sel_any_s && (sel_idx_s == FU_W'(i)) && !byp_grant_s;
            pop_s[i]  = q_grant_s && (q_idx_s == FU_W'(i));
        end
    end

    // Grant outputs to ROB, RS and PRF query; all data forced to zero when nothing issues
    always_comb begin
        rob_we     = 1'b0;
        rs_we      = {NUM_FU{1'b0}};
        query_ps1  = {PREG_W{1'b0}};
        query_ps2  = {PREG_W{1'b0}};
        rob_pd_new = {PREG_W{1'b0}};
        rob_pd_old = {PREG_W{1'b0}};
        rob_pc     = 32'h0000_0000;
        rs_pc      = 32'h0000_0000;
        rs_prd     = {PREG_W{1'b0}};
        rs_pr1     = {PREG_W{1'b0}};
        rs_pr2     = {PREG_W{1'b0}};
        rs_pr1_rdy = 1'b0;
        rs_pr2_rdy = 1'b0;
        rs_rob_idx = {ROB_TAG_W{1'b0}};
        rs_payload = {PAYLOAD_W{1'b0}};
        if (grant_s) begin
            rob_we             = 1'b1;
            rs_we[grant_idx_s] = 1'b1;
            query_ps1          = grant_op_s.ps1;
            query_ps2          = grant_op_s.ps2;
            rob_pd_new         = grant_op_s.pd_new;
            rob_pd_old         = grant_op_s.pd_old;
            rob_pc             = grant_op_s.pc;
            rs_pc              = grant_op_s.pc;
            rs_prd             = grant_op_s.pd_new;
            rs_pr1             = grant_op_s.ps1;
            rs_pr2             = grant_op_s.ps2;
            rs_pr1_rdy         = src_ready(grant_op_s.ps1, pr1_is_ready, cdb_valid, cdb_tag);
            rs_pr2_rdy         = src_ready(grant_op_s.ps2, pr2_is_ready, cdb_valid, cdb_tag);
            rs_rob_idx         = rob_tag_in;
            rs_payload         = grant_op_s.payload;
        end else begin
            rob_we = 1'b0;
        end
    end

    // FIFO pointers/counts and the round-robin pointer; flush clears like reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
                count_r[i]  <= {CNT_W{1'b0}};
            end
            rr_ptr_r <= {FU_W{1'b0}};
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
                count_r[i]  <= {CNT_W{1'b0}};
            end
            rr_ptr_r <= {FU_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
                    2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
                    default: count_r[i] <= count_r[i];
                endcase
            end
            if (grant_s) begin
                rr_ptr_r <= next_rr_s;
            end
        end
    end

    // FIFO storage; contents are only ever read behind a non-zero count
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push_s[i]) begin
                fifo_mem_r[i][wr_ptr_r[i]] <= in_op_s;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_rr_multi_fu.sv
// Self-checking bench for dispatch_rr_multi_fu: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours DISPATCH_BYPASS_EN like the design.
`timescale 1ns/1ps
module tb_dispatch_rr_multi_fu;
    localparam int NF = 3, DEPTH = 2, NC = 3, PW = 7, RW = 5, LW = 64;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, nr_valid;
    logic [NF-1:0] in_fu_sel, rs_has_space, rs_we;
    logic [PW-1:0] in_ps1, in_ps2, in_pd_new, in_pd_old, nr_reg, query_ps1, query_ps2;
    logic [31:0] in_pc, rob_pc, rs_pc;
    logic [LW-1:0] in_payload, rs_payload;
    logic pr1_is_ready, pr2_is_ready, rob_full, rob_we, rs_pr1_rdy, rs_pr2_rdy;
    logic [NC-1:0] cdb_valid;
    logic [NC*PW-1:0] cdb_tag;
    logic [RW-1:0] rob_tag_in, rs_rob_idx;
    logic [PW-1:0] rob_pd_new, rob_pd_old, rs_prd, rs_pr1, rs_pr2;

    always #5 clk = ~clk;

    dispatch_rr_multi_fu dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_fu_sel(in_fu_sel), .in_ps1(in_ps1), .in_ps2(in_ps2), .in_pd_new(in_pd_new),
        .in_pd_old(in_pd_old), .in_pc(in_pc), .in_payload(in_payload), .nr_valid(nr_valid),
        .nr_reg(nr_reg), .query_ps1(query_ps1), .query_ps2(query_ps2),
        .pr1_is_ready(pr1_is_ready), .pr2_is_ready(pr2_is_ready), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .rob_full(rob_full), .rob_tag_in(rob_tag_in), .rob_we(rob_we),
        .rob_pd_new(rob_pd_new), .rob_pd_old(rob_pd_old), .rob_pc(rob_pc),
        .rs_has_space(rs_has_space), .rs_we(rs_we), .rs_pc(rs_pc), .rs_prd(rs_prd),
        .rs_pr1(rs_pr1), .rs_pr2(rs_pr2), .rs_pr1_rdy(rs_pr1_rdy), .rs_pr2_rdy(rs_pr2_rdy),
        .rs_rob_idx(rs_rob_idx), .rs_payload(rs_payload)
    );

    typedef struct {
        logic [PW-1:0] ps1, ps2, pd_new, pd_old;
        logic [31:0]   pc;
        logic [LW-1:0] payload;
    } op_t;

    op_t mq [NF][$];
    int  rr;
    int  n_checks = 0;
    int  n_pass = 0;
    int  opn = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit cdb_hit(input logic [PW-1:0] tag);
        bit h = 1'b0;
        for (int k = 0; k < NC; k++)
            if (cdb_valid[k] && cdb_tag[k*PW +: PW] == tag) h = 1'b1;
        return h;
    endfunction

    // Reference model: evaluate outputs mid-cycle, then apply the coming clock edge to the queues.
    always @(negedge clk) begin : model
        int sel, g, idx;
        bit any, acc, gq, gb, exp_ready, r1, r2;
        op_t op, inop;
        logic [NF-1:0] ew;
        logic [255:0] exp_data, act_data;
        if (reset) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            rr = 0;
            check("reset_rob_we", rob_we, 1'b0);
            check("reset_rs_we", rs_we, 3'b000);
        end else begin
            any = (in_fu_sel != 3'b000);
            sel = 0;
            for (int i = NF - 1; i >= 0; i--) if (in_fu_sel[i]) sel = i;
            exp_ready = !flush && !(any && mq[sel].size() >= DEPTH);
            acc = in_valid && exp_ready;
            inop = '{in_ps1, in_ps2, in_pd_new, in_pd_old, in_pc, in_payload};
            gq = 1'b0; gb = 1'b0; g = 0;
            if (!flush && !rob_full)
                for (int k = 0; k < NF; k++) begin
                    idx = (rr + k) % NF;
                    if (!gq && mq[idx].size() > 0 && rs_has_space[idx]) begin gq = 1'b1; g = idx; end
                end
`ifdef DISPATCH_BYPASS_EN
            if (!gq && acc && any && mq[sel].size() == 0 && rs_has_space[sel] && !rob_full) begin
                gb = 1'b1; g = sel;
            end
`endif
            ew = 3'b000;
            exp_data = '0;
            if (gq || gb) begin
                op = gq ? mq[g][0] : inop;
                ew[g] = 1'b1;
                r1 = (op.ps1 == 7'd0) || pr1_is_ready || cdb_hit(op.ps1);
                r2 = (op.ps2 == 7'd0) || pr2_is_ready || cdb_hit(op.ps2);
                exp_data = {op.ps1, op.ps2, op.pd_new, op.pd_old, op.pc, op.pc, op.pd_new,
                            op.ps1, op.ps2, rob_tag_in, op.payload, r1, r2};
            end
            act_data = {query_ps1, query_ps2, rob_pd_new, rob_pd_old, rob_pc, rs_pc, rs_prd,
                        rs_pr1, rs_pr2, rs_rob_idx, rs_payload, rs_pr1_rdy, rs_pr2_rdy};
            check("in_ready", in_ready, exp_ready);
            check("nr", {nr_valid, nr_reg}, {acc && any && (in_pd_new != 7'd0), in_pd_new});
            check("grant", {rob_we, rs_we}, {(gq || gb), ew});
            check("grant_data", act_data, exp_data);
            if (flush) begin
                for (int i = 0; i < NF; i++) mq[i].delete();
                rr = 0;
            end else begin
                if (gq) void'(mq[g].pop_front());
                if (acc && any && !gb) mq[sel].push_back(inop);
                if (gq || gb) rr = (g + 1) % NF;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [NF-1:0] s, input logic [PW-1:0] p1,
                          input logic [PW-1:0] p2, input logic [PW-1:0] pd);
        opn++;
        in_valid = v; in_fu_sel = s; in_ps1 = p1; in_ps2 = p2; in_pd_new = pd;
        in_pd_old = pd ^ 7'h55;
        in_pc = 32'h0000_1000 + 32'(opn * 4);
        in_payload = {16'hA5A5, 16'(opn), 32'(opn * 7)};
    endtask

    logic [NF-1:0] seq [4];

    initial begin
        seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_fu_sel = 3'b000;
        in_ps1 = 7'd0; in_ps2 = 7'd0; in_pd_new = 7'd0; in_pd_old = 7'd0;
        in_pc = 32'd0; in_payload = 64'd0; pr1_is_ready = 1'b1; pr2_is_ready = 1'b1;
        cdb_valid = 3'b000; cdb_tag = 21'd0; rob_full = 1'b0; rob_tag_in = 5'd3;
        rs_has_space = 3'b111;
        tick(); tick();
        @(negedge clk);
        check("lit_reset_rob_we", rob_we, 1'b0);
        check("lit_reset_in_ready", in_ready, 1'b1);
        tick(); reset = 1'b0;

        // single op to FU0, pd=5
        set_op(1'b1, 3'b001, 7'd1, 7'd2, 7'd5);
        @(negedge clk);
        check("lit_t1_nr", {nr_valid, nr_reg}, {1'b1, 7'd5});
`ifdef DISPATCH_BYPASS_EN
        check("lit_t1_rs_we_c0", {rob_we, rs_we}, {1'b1, 3'b001});
`else
        check("lit_t1_rs_we_c0", {rob_we, rs_we}, {1'b0, 3'b000});
`endif
        tick(); in_valid = 1'b0;
        @(negedge clk);
`ifdef DISPATCH_BYPASS_EN
        check("lit_t1_rs_we_c1", {rob_we, rs_we}, {1'b0, 3'b000});
`else
        check("lit_t1_rs_we_c1", {rob_we, rs_we}, {1'b1, 3'b001});
`endif

        // FU0 back-pressured: third op refused, FU1 still accepted
        tick(); rs_has_space = 3'b110; set_op(1'b1, 3'b001, 7'd3, 7'd4, 7'd10);
        tick(); set_op(1'b1, 3'b001, 7'd3, 7'd4, 7'd11);
        tick(); set_op(1'b1, 3'b001, 7'd3, 7'd4, 7'd12);
        @(negedge clk); check("lit_fu0_full", in_ready, 1'b0);
        tick(); set_op(1'b1, 3'b010, 7'd3, 7'd4, 7'd13);
        @(negedge clk); check("lit_fu1_accept", in_ready, 1'b1);
        tick(); in_valid = 1'b0; rs_has_space = 3'b111;
        repeat (4) tick();

        // flush with two ops queued, then a pd_new=0 op
        rob_full = 1'b1; set_op(1'b1, 3'b010, 7'd5, 7'd6, 7'd20);
        tick(); set_op(1'b1, 3'b100, 7'd5, 7'd6, 7'd21);
        tick(); in_valid = 1'b0; flush = 1'b1;
        @(negedge clk); check("lit_flush_cycle", {in_ready, rob_we, rs_we}, 5'b0);
        tick(); flush = 1'b0; rob_full = 1'b0;
        @(negedge clk); check("lit_post_flush_empty", {rob_we, rs_we}, 4'b0);
        tick(); set_op(1'b1, 3'b001, 7'd3, 7'd4, 7'd0);
        @(negedge clk); check("lit_pd0_nr_valid", {in_ready, nr_valid}, 2'b10);
        tick(); in_valid = 1'b0; tick(); tick();

        // rob_full holds queued ops; release shows round-robin from rr_ptr=0
        flush = 1'b1; tick(); flush = 1'b0; rob_full = 1'b1;
        set_op(1'b1, 3'b001, 7'd1, 7'd2, 7'd30);
        @(negedge clk); check("lit_robfull_0", rob_we, 1'b0);
        tick(); set_op(1'b1, 3'b001, 7'd1, 7'd2, 7'd31);
        @(negedge clk); check("lit_robfull_1", rob_we, 1'b0);
        tick(); set_op(1'b1, 3'b010, 7'd1, 7'd2, 7'd32);
        @(negedge clk); check("lit_robfull_2", rob_we, 1'b0);
        tick(); set_op(1'b1, 3'b100, 7'd1, 7'd2, 7'd33);
        @(negedge clk); check("lit_robfull_3", rob_we, 1'b0);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            rob_full = 1'b0;
            @(negedge clk);
            check($sformatf("lit_rr_seq%0d", i), {rob_we, rs_we}, {1'b1, seq[i]});
            if (i == 0) check("lit_rr_pd", rs_prd, 7'd30);
        end

        // CDB wakeup at grant: ps1=9 on port1, ps2=0
        tick(); pr1_is_ready = 1'b0; pr2_is_ready = 1'b0;
        cdb_valid = 3'b010; cdb_tag = {7'd1, 7'd9, 7'd6};
        set_op(1'b1, 3'b010, 7'd9, 7'd0, 7'd40);
`ifndef DISPATCH_BYPASS_EN
        tick(); in_valid = 1'b0;
`endif
        @(negedge clk);
        check("lit_cdb_rdy", {rs_we, rs_pr1_rdy, rs_pr2_rdy}, {3'b010, 1'b1, 1'b1});
        tick(); cdb_valid = 3'b001; set_op(1'b1, 3'b010, 7'd9, 7'd8, 7'd41);
`ifndef DISPATCH_BYPASS_EN
        tick(); in_valid = 1'b0;
`endif
        @(negedge clk);
        check("lit_cdb_miss", {rs_we, rs_pr1_rdy, rs_pr2_rdy}, {3'b010, 1'b0, 1'b0});
        tick(); in_valid = 1'b0; pr1_is_ready = 1'b1; pr2_is_ready = 1'b1; cdb_valid = 3'b000;

        // reset mid-operation drops queued ops
        rob_full = 1'b1; set_op(1'b1, 3'b100, 7'd1, 7'd1, 7'd50);
        tick(); set_op(1'b1, 3'b001, 7'd1, 7'd1, 7'd51);
        tick(); in_valid = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; rob_full = 1'b0;
        @(negedge clk); check("lit_reset_drop", {rob_we, rs_we}, 4'b0);

        // mixed traffic checked by the model every cycle
        for (int c = 0; c < 80; c++) begin
            tick();
            set_op(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                   7'($urandom_range(0, 12)), 7'($urandom_range(0, 12)), 7'($urandom_range(0, 20)));
            rs_has_space = 3'($urandom_range(0, 7));
            rob_full = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            cdb_valid = 3'($urandom_range(0, 7));
            cdb_tag = {7'($urandom_range(0, 12)), 7'($urandom_range(0, 12)), 7'($urandom_range(0, 12))};
            pr1_is_ready = 1'($urandom_range(0, 1));
            pr2_is_ready = 1'($urandom_range(0, 1));
            rob_tag_in = 5'($urandom_range(0, 31));
        end
        tick(); in_valid = 1'b0; flush = 1'b0; rob_full = 1'b0; rs_has_space = 3'b111;
        repeat (8) tick();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
